// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared state encoding and truth-table masks for gate sweeps
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Bit v is the expected output for input vector v (a = MSB of v)
   localparam logic [15:0] AND4_EXPECT  = 16'h8000;
   localparam logic [15:0] NAND4_EXPECT = 16'h7FFF;
   localparam logic [15:0] OR4_EXPECT   = 16'hFFFE;
   localparam logic [15:0] NOR4_EXPECT  = 16'h0001;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter timing the settle window after each new vector
module settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   // Loading SETTLE-1 gives exactly SETTLE cycles until expiry; SETTLE=0 pins the count at 0
   localparam logic [CW-1:0] LOAD_VAL = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive input sweep of a single-output gate against a truth table
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int                 N_IN   = 4,
   parameter int                 SETTLE = 1,
   parameter logic [2**N_IN-1:0] EXPECT = AND4_EXPECT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   fail_count,
   output logic [N_IN-1:0] first_fail_vec
);

   localparam logic [N_IN-1:0] LAST_VEC    = '1;
   localparam state_t          FIRST_STATE = (SETTLE > 0) ? WAIT : SAMPLE;

   state_t        state;
   state_t        state_next;
   logic          timer_load;
   logic          timer_expired;
   logic          do_start;
   logic          do_sample;
   logic          mismatch;
   logic [N_IN:0] fail_next;

   settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort takes priority over a pending sample, including the final vector
   always_comb begin
      state_next = state;
      timer_load = 1'b0;
      do_start   = 1'b0;
      do_sample  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               do_start   = 1'b1;
               timer_load = 1'b1;
               state_next = FIRST_STATE;
            end
         end
         WAIT: begin
            if (abort) begin
               state_next = IDLE;
            end else if (timer_expired) begin
               state_next = SAMPLE;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_next = IDLE;
            end else begin
               do_sample = 1'b1;
               if (dut_in == LAST_VEC) begin
                  state_next = DONE;
               end else begin
                  timer_load = 1'b1;
                  state_next = FIRST_STATE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign mismatch  = (dut_out != EXPECT[dut_in]);
   assign fail_next = fail_count + {{N_IN{1'b0}}, mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_in         <= '0;
         pass           <= 1'b0;
         fail_count     <= '0;
         first_fail_vec <= '0;
      end else begin
         if (do_start) begin
            dut_in         <= '0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
         end
         if (do_sample) begin
            if (mismatch) begin
               fail_count <= fail_next;
               if (fail_count == '0) begin
                  first_fail_vec <= dut_in;
               end
            end
            if (dut_in != LAST_VEC) begin
               dut_in <= dut_in + N_IN'(1);
            end else begin
               pass <= (fail_next == '0);
            end
         end
      end
   end

   assign busy = (state == WAIT) || (state == SAMPLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - scoreboard bench for gate_sweep_ctrl (default and SETTLE=0 instances)
module tb_gate_sweep_ctrl;

   typedef struct {
      logic       pass;
      int         fc;
      int         ffv;
      int         at_edge;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start_a, abort_a, out_a;
   logic [3:0] din_a, ffv_a;
   logic [4:0] fc_a;
   logic       busy_a, done_a, pass_a;
   logic       start_b, abort_b, out_b;
   logic [3:0] din_b, ffv_b;
   logic [4:0] fc_b;
   logic       busy_b, done_b, pass_b;
   logic [1:0] mode;
   int         cyc;
   int         n_vec;
   int         n_err;
   exp_t       qa[$];
   exp_t       qb[$];

   gate_sweep_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .dut_in(din_a), .dut_out(out_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .fail_count(fc_a), .first_fail_vec(ffv_a)
   );

   gate_sweep_ctrl #(.SETTLE(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .dut_in(din_b), .dut_out(out_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .fail_count(fc_b), .first_fail_vec(ffv_b)
   );

   // mode 0: healthy AND4, 1: stuck-at-0, 2: stuck-at-1
   always_comb begin
      out_a = 1'b0;
      case (mode)
         2'd0:    out_a = &din_a;
         2'd2:    out_a = 1'b1;
         default: out_a = 1'b0;
      endcase
   end
   assign out_b = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input logic p, input int fc, input int ffv);
      check({tag, "_done_edge"}, cyc, e.at_edge);
      check({tag, "_pass"}, int'(p), int'(e.pass));
      check({tag, "_fail_count"}, fc, e.fc);
      if (e.fc != 0) check({tag, "_first_fail"}, ffv, e.ffv);
   endtask

   always @(negedge clk) begin
      if (rst_n && done_a) begin
         if (qa.size() == 0) check("a_unexpected_done", 1, 0);
         else compare("a", qa.pop_front(), pass_a, int'(fc_a), int'(ffv_a));
      end
      if (rst_n && done_b) begin
         if (qb.size() == 0) check("b_unexpected_done", 1, 0);
         else compare("b", qb.pop_front(), pass_b, int'(fc_b), int'(ffv_b));
      end
   end

   task automatic to_neg_after(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 120; i++) begin
         if (qa.size() == 0 && qb.size() == 0) break;
         @(negedge clk);
         #1;
      end
      check("scoreboard_drained", qa.size() + qb.size(), 0);
   endtask

   task automatic kick_a(output int e0);
      start_a = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e0;
      n_vec = 0; n_err = 0; cyc = 0;
      rst_n = 1'b0; mode = 2'd0;
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      #1;
      check("reset_outputs_a", int'({din_a, busy_a, done_a, pass_a, fc_a, ffv_a}), 0);
      check("reset_outputs_b", int'({din_b, busy_b, done_b, pass_b, fc_b, ffv_b}), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // healthy AND4, default timing
      mode = 2'd0;
      qa.push_back('{pass: 1'b1, fc: 0, ffv: 0, at_edge: cyc + 1 + 32});
      kick_a(e0);
      to_neg_after(e0 + 1);
      check("t1_vec0", int'(din_a), 0);
      check("t1_busy", int'(busy_a), 1);
      to_neg_after(e0 + 11);
      check("t1_vec5", int'(din_a), 5);
      to_neg_after(e0 + 31);
      check("t1_vec15", int'(din_a), 15);
      drain();
      to_neg_after(e0 + 34);
      check("t1_idle_busy", int'(busy_a), 0);
      check("t1_idle_hold_vec", int'(din_a), 15);
      check("t1_pass_held", int'(pass_a), 1);

      // stuck-at-0
      mode = 2'd1;
      qa.push_back('{pass: 1'b0, fc: 1, ffv: 15, at_edge: cyc + 1 + 32});
      kick_a(e0);
      drain();
      @(negedge clk);

      // stuck-at-1 on the SETTLE=0 instance
      qb.push_back('{pass: 1'b0, fc: 15, ffv: 0, at_edge: cyc + 1 + 16});
      start_b = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start_b = 1'b0;
      to_neg_after(e0 + 5);
      check("t3_vec5", int'(din_b), 5);
      drain();
      @(negedge clk);

      // abort in SAMPLE of vector 6 with start held high
      mode = 2'd0;
      start_a = 1'b1;
      e0 = cyc + 1;
      to_neg_after(e0 + 13);
      check("t4_vec6", int'(din_a), 6);
      check("t4_busy_before", int'(busy_a), 1);
      abort_a = 1'b1;
      start_a = 1'b0;
      @(negedge clk);
      abort_a = 1'b0;
      check("t4_busy_after", int'(busy_a), 0);
      check("t4_done_after", int'(done_a), 0);
      check("t4_pass_after", int'(pass_a), 0);
      check("t4_vec_hold", int'(din_a), 6);
      repeat (3) @(negedge clk);
      check("t4_stays_idle", int'(busy_a), 0);

      // asynchronous reset at vector 9, with stuck-at-1 partial results
      mode = 2'd2;
      kick_a(e0);
      to_neg_after(e0 + 19);
      check("t5_vec9", int'(din_a), 9);
      check("t5_partial_fails", int'(fc_a), 9);
      #1 rst_n = 1'b0;
      #1;
      check("t5_async_reset", int'({din_a, busy_a, done_a, pass_a, fc_a, ffv_a}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mode = 2'd0;
      qa.push_back('{pass: 1'b1, fc: 0, ffv: 0, at_edge: cyc + 1 + 32});
      kick_a(e0);
      drain();
      @(negedge clk);

      // back-to-back sweeps with start held; DONE + one IDLE cycle between sweeps
      mode = 2'd1;
      start_a = 1'b1;
      e0 = cyc + 1;
      qa.push_back('{pass: 1'b0, fc: 1, ffv: 15, at_edge: e0 + 32});
      qa.push_back('{pass: 1'b0, fc: 1, ffv: 15, at_edge: e0 + 66});
      to_neg_after(e0 + 33);
      check("t6_count_before_restart", int'(fc_a), 1);
      to_neg_after(e0 + 34);
      check("t6_restart_clears", int'(fc_a), 0);
      check("t6_restart_busy", int'(busy_a), 1);
      to_neg_after(e0 + 40);
      start_a = 1'b0;
      drain();
      repeat (4) @(negedge clk);
      check("t6_no_third_sweep", int'(busy_a), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
